// File: rtl/mac_cam_table.sv
// MAC learning table: sequential scan over a registered-read RAM, per-entry
// valid flops, learn with round-robin eviction when full, single-cycle flush.
module mac_cam_table #(
  parameter int ADDR_WIDTH = 4,
  parameter int KEY_WIDTH  = 48,
  parameter int PORT_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_learn,
  input  logic [KEY_WIDTH-1:0]  req_key,
  input  logic [PORT_WIDTH-1:0] req_port,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic                  rsp_evict,
  output logic [ADDR_WIDTH-1:0] rsp_index,
  output logic [PORT_WIDTH-1:0] rsp_port,
  output logic [ADDR_WIDTH:0]   entry_count
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int WORD_W = KEY_WIDTH + PORT_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] SCAN_END = (ADDR_WIDTH+1)'(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;

  typedef struct packed {
    logic                  learn;
    logic [KEY_WIDTH-1:0]  key;
    logic [PORT_WIDTH-1:0] port;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [WORD_W-1:0]     rd_data;
  logic [ADDR_WIDTH:0]   scan_idx;
  logic                  cmp_vld;
  logic [ADDR_WIDTH-1:0] cmp_idx;
  logic                  free_found;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  wr_new;
  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH-1:0] rr_ptr;
  logic                  hit_q, evict_q;
  logic [PORT_WIDTH-1:0] port_q;

  logic accept, match, scan_done, wr_en;

  assign req_ready = (state == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign match     = (state == SCAN) & cmp_vld & valid[cmp_idx]
                   & (rd_data[WORD_W-1:PORT_WIDTH] == req_q.key);
  // One drain cycle after the last compare so a miss lands at DEPTH+2.
  assign scan_done = (state == SCAN) & (scan_idx == SCAN_END);
  assign wr_en     = (state == WRITE) & ~flush;

  // RAM is not reset; read returns old data on a same-address write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= {req_q.key, req_q.port};
    rd_data <= mem[scan_idx[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SCAN;
      SCAN:  if (match || scan_done) state_nxt = req_q.learn ? WRITE : RESP;
      WRITE: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      req_q       <= '0;
      scan_idx    <= '0;
      cmp_vld     <= 1'b0;
      cmp_idx     <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      wr_idx      <= '0;
      wr_new      <= 1'b0;
      valid       <= '0;
      rr_ptr      <= '0;
      entry_count <= '0;
      hit_q       <= 1'b0;
      evict_q     <= 1'b0;
      port_q      <= '0;
    end else if (flush) begin
      valid       <= '0;
      rr_ptr      <= '0;
      entry_count <= '0;
      cmp_vld     <= 1'b0;
    end else begin
      if (accept) begin
        req_q      <= '{learn: req_learn, key: req_key, port: req_port};
        scan_idx   <= '0;
        cmp_vld    <= 1'b0;
        free_found <= 1'b0;
      end
      if (state == SCAN) begin
        scan_idx <= scan_idx + (ADDR_WIDTH+1)'(1);
        cmp_vld  <= (scan_idx < DEPTH_W);
        cmp_idx  <= scan_idx[ADDR_WIDTH-1:0];
        if (cmp_vld && !valid[cmp_idx] && !free_found) begin
          free_found <= 1'b1;
          free_idx   <= cmp_idx;
        end
      end
      if (match) begin
        wr_idx  <= cmp_idx;
        wr_new  <= 1'b0;
        hit_q   <= 1'b1;
        evict_q <= 1'b0;
        port_q  <= req_q.learn ? req_q.port : rd_data[PORT_WIDTH-1:0];
      end else if (scan_done) begin
        hit_q  <= 1'b0;
        port_q <= req_q.learn ? req_q.port : '0;
        wr_new <= req_q.learn & free_found;
        // Lookup misses report index 0; full-table learns take the rr slot.
        if (!req_q.learn) begin
          wr_idx  <= '0;
          evict_q <= 1'b0;
        end else if (free_found) begin
          wr_idx  <= free_idx;
          evict_q <= 1'b0;
        end else begin
          wr_idx  <= rr_ptr;
          evict_q <= 1'b1;
        end
      end
      if (state == WRITE) begin
        valid[wr_idx] <= 1'b1;
        if (wr_new)  entry_count <= entry_count + (ADDR_WIDTH+1)'(1);
        if (evict_q) rr_ptr      <= rr_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_hit   = rsp_valid & hit_q;
  assign rsp_evict = rsp_valid & evict_q;
  assign rsp_index = rsp_valid ? wr_idx : '0;
  assign rsp_port  = rsp_valid ? port_q : '0;

endmodule

// File: tb/tb_mac_cam_table.sv
// Random and directed learn/lookup traffic against an array-based table model
// tracking latency, hit/evict, index, port and occupancy.
module tb_mac_cam_table;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        arst_n, flush, req_valid, req_ready, req_learn;
  logic [47:0] req_key;
  logic [1:0]  req_port;
  logic        rsp_valid, rsp_hit, rsp_evict;
  logic [3:0]  rsp_index;
  logic [1:0]  rsp_port;
  logic [4:0]  entry_count;

  int n_chk = 0;
  int n_err = 0;

  logic [47:0] m_key  [DEPTH];
  logic [1:0]  m_port [DEPTH];
  bit          m_vld  [DEPTH];
  int          m_rr, m_cnt;

  mac_cam_table dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_learn(req_learn),
    .req_key(req_key), .req_port(req_port),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_evict(rsp_evict),
    .rsp_index(rsp_index), .rsp_port(rsp_port), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_rr  = 0;
    m_cnt = 0;
  endtask

  // One request end-to-end; expectations come from the model before issue.
  task automatic do_req(input bit learn, input logic [47:0] key, input logic [1:0] port);
    int hit_i, free_i, exp_lat, exp_idx, n;
    bit exp_hit, exp_ev, got;
    logic [1:0] exp_port;
    hit_i = -1; free_i = -1; exp_ev = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (m_vld[i] && m_key[i] == key) hit_i = i;
      if (!m_vld[i]) free_i = i;
    end
    exp_hit = (hit_i >= 0);
    if (!learn) begin
      exp_lat  = exp_hit ? hit_i + 2 : DEPTH + 2;
      exp_idx  = exp_hit ? hit_i : 0;
      exp_port = exp_hit ? m_port[hit_i] : 2'd0;
    end else begin
      exp_port = port;
      if (exp_hit) begin
        exp_lat = hit_i + 3;
        exp_idx = hit_i;
      end else begin
        exp_lat = DEPTH + 3;
        if (free_i >= 0) begin
          exp_idx = free_i;
          m_cnt++;
        end else begin
          exp_idx = m_rr;
          exp_ev  = 1'b1;
          m_rr    = (m_rr + 1) % DEPTH;
        end
      end
      m_vld[exp_idx]  = 1'b1;
      m_key[exp_idx]  = key;
      m_port[exp_idx] = port;
    end

    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1; req_learn = learn; req_key = key; req_port = port;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_learn = 1'($urandom); req_key = {$urandom, $urandom}; req_port = 2'($urandom);
    chk("rsp_early", rsp_valid, 0);
    n = 0; got = 1'b0;
    while (!got && n < DEPTH + 10) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", got, 1);
    if (got) begin
      chk("latency", n, exp_lat);
      chk("rsp_hit", rsp_hit, exp_hit);
      chk("rsp_evict", rsp_evict, exp_ev);
      chk("rsp_index", rsp_index, exp_idx);
      chk("rsp_port", rsp_port, exp_port);
      chk("entry_count", entry_count, m_cnt);
      @(posedge clk); #1;
      chk("rsp_strobe", rsp_valid, 0);
    end
  endtask

  initial begin
    logic [47:0] key;
    bit saw;
    arst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_learn = 1'b0;
    req_key = '0; req_port = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_index", rsp_index, 0);
    chk("rst_count", entry_count, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk); arst_n = 1'b1;

    do_req(1'b0, 48'h0011_2233_4455, 2'd0);
    for (int i = 0; i < 4; i++) do_req(1'b1, 48'hA0 + 48'(i), 2'(i));
    do_req(1'b0, 48'hA2, 2'd0);
    do_req(1'b1, 48'hA1, 2'd3);
    do_req(1'b0, 48'hA1, 2'd0);
    for (int i = 4; i < DEPTH; i++) do_req(1'b1, 48'hC0 + 48'(i), 2'($urandom));
    do_req(1'b1, 48'hB0, 2'd1);
    do_req(1'b1, 48'hB1, 2'd2);
    do_req(1'b0, 48'hA0, 2'd0);
    do_req(1'b0, 48'hB1, 2'd0);

    // Flush in the middle of a learn scan.
    @(negedge clk);
    req_valid = 1'b1; req_learn = 1'b1; req_key = 48'hD0; req_port = 2'd1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    #1 chk("flush_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("flush_count", entry_count, 0);
    @(negedge clk); flush = 1'b0;
    model_clear();
    saw = 1'b0;
    repeat (DEPTH + 6) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1'b1;
    end
    chk("flush_no_rsp", saw, 0);
    do_req(1'b1, 48'hE0, 2'd2);

    for (int t = 0; t < 80; t++) begin
      key = 48'h5E00_0000_0000 | 48'($urandom_range(0, 23));
      do_req(1'($urandom), key, 2'($urandom));
    end

    // Reset in the middle of a lookup scan; learned entries must vanish.
    @(negedge clk);
    req_valid = 1'b1; req_learn = 1'b0; req_key = 48'hE0; req_port = 2'd0;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); arst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_hit", rsp_hit, 0);
    chk("arst_count", entry_count, 0);
    chk("arst_ready", req_ready, 1);
    @(negedge clk); arst_n = 1'b1;
    model_clear();
    do_req(1'b0, 48'hE0, 2'd0);
    for (int i = 0; i < 4; i++) do_req(1'b0, 48'h5E00_0000_0000 | 48'(i), 2'd0);
    do_req(1'b1, 48'hF0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
